// File: rtl/rrip_victim_ctrl_pkg.sv
// Shared definitions for the RRIP victim controller.
//   rrip_state_t  : controller FSM states (IDLE, SEARCH, AGE, RESP)
//   rrpv_distant  : the "distant re-reference" RRPV value for an M-bit RRPV
//   way_w         : way-number width for a given associativity (at least 1)
package rrip_victim_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        AGE    = 2'd2,
        RESP   = 2'd3
    } rrip_state_t;

    function automatic int rrpv_distant(input int m);
        return (1 << m) - 1;
    endfunction

    function automatic int way_w(input int assoc);
        return (assoc > 1) ? $clog2(assoc) : 1;
    endfunction

endpackage

// File: rtl/rrip_victim_ctrl_way_scan.sv
// rrip_way_scan: combinational priority finder over one set's RRPVs.
//   rrpv  in  ASSOCIATIVITY x M  RRPV of every way in the set
//   found out 1                  at least one way holds DISTANT
//   way   out WAY_W              lowest-numbered way holding DISTANT (0 if none)
module rrip_way_scan
    import rrip_victim_ctrl_pkg::*;
#(
    parameter int ASSOCIATIVITY = 4,
    parameter int M             = 2,
    parameter int WAY_W         = 2
) (
    input  logic [ASSOCIATIVITY-1:0][M-1:0] rrpv,
    output logic                            found,
    output logic [WAY_W-1:0]                way
);

    localparam logic [M-1:0] DISTANT = M'(rrpv_distant(M));

    // Walk from the highest way down so the lowest matching way is the last
    // one written and therefore wins.
    always_comb begin
        found = 1'b0;
        way   = '0;
        for (int i = ASSOCIATIVITY - 1; i >= 0; i--) begin
            if (rrpv[i] == DISTANT) begin
                found = 1'b1;
                way   = WAY_W'(i);
            end
        end
    end

endmodule

// File: rtl/rrip_victim_ctrl.sv
// rrip_victim_ctrl: per-set RRIP replacement controller.
// Owns the RRPV array, promotes a way to RRPV 0 on a hit, and on a miss finds
// (ageing the set as needed) a DISTANT way which it reinstalls with the
// SHiP-predicted RRPV.
//
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   halt              pipeline stall: freezes state, array and outputs
//   req_valid/ready   request handshake (see below)
//   req_hit           1 = hit, 0 = miss
//   req_index         set index
//   req_hit_way       hitting way (meaningful only on a hit)
//   fill_rrpv         insertion RRPV for the victim (meaningful only on a miss)
//   resp_valid        one-cycle response strobe (held while halted)
//   resp_hit          response belongs to a hit
//   resp_way          promoted way (hit) or chosen victim (miss)
//   resp_index        set of the response
//   dbg_state         current FSM state
//
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both high. req_ready is high only in IDLE without halt; the
// requester keeps its request stable until it transfers. Request fields are
// sampled only on the transfer edge.
module rrip_victim_ctrl
    import rrip_victim_ctrl_pkg::*;
#(
    parameter  int ASSOCIATIVITY = 4,
    parameter  int INDEX_WIDTH   = 5,
    parameter  int DEPTH         = 32,
    parameter  int M             = 2,
    localparam int WAY_W         = way_w(ASSOCIATIVITY)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   halt,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_hit,
    input  logic [INDEX_WIDTH-1:0] req_index,
    input  logic [WAY_W-1:0]       req_hit_way,
    input  logic [M-1:0]           fill_rrpv,
    output logic                   resp_valid,
    output logic                   resp_hit,
    output logic [WAY_W-1:0]       resp_way,
    output logic [INDEX_WIDTH-1:0] resp_index,
    output rrip_state_t            dbg_state
);

    localparam logic [M-1:0] DISTANT = M'(rrpv_distant(M));

    rrip_state_t            state_q;
    logic [INDEX_WIDTH-1:0] lat_index;
    logic [M-1:0]           lat_fill;
    logic [M-1:0]           rrpv_q [ASSOCIATIVITY][DEPTH];

    logic [ASSOCIATIVITY-1:0][M-1:0] set_rrpv;
    logic                            scan_found;
    logic [WAY_W-1:0]                scan_way;

    assign req_ready = (state_q == IDLE) && !halt;
    assign dbg_state = state_q;

    // The scanner always looks at the set latched by the in-flight miss.
    always_comb begin
        set_rrpv = '0;
        for (int w = 0; w < ASSOCIATIVITY; w++) begin
            set_rrpv[w] = rrpv_q[w][lat_index];
        end
    end

    rrip_way_scan #(
        .ASSOCIATIVITY(ASSOCIATIVITY),
        .M            (M),
        .WAY_W        (WAY_W)
    ) u_scan (
        .rrpv (set_rrpv),
        .found(scan_found),
        .way  (scan_way)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            lat_index  <= '0;
            lat_fill   <= '0;
            resp_valid <= 1'b0;
            resp_hit   <= 1'b0;
            resp_way   <= '0;
            resp_index <= '0;
            for (int w = 0; w < ASSOCIATIVITY; w++) begin
                for (int s = 0; s < DEPTH; s++) begin
                    rrpv_q[w][s] <= DISTANT;
                end
            end
        end else if (!halt) begin
            resp_valid <= 1'b0;
            case (state_q)
                IDLE: begin
                    // req_ready is implied here: IDLE and not halted.
                    if (req_valid) begin
                        lat_index <= req_index;
                        lat_fill  <= fill_rrpv;
                        if (req_hit) begin
                            rrpv_q[req_hit_way][req_index] <= '0;
                            resp_valid <= 1'b1;
                            resp_hit   <= 1'b1;
                            resp_way   <= req_hit_way;
                            resp_index <= req_index;
                            state_q    <= RESP;
                        end else begin
                            state_q <= SEARCH;
                        end
                    end
                end
                SEARCH: begin
                    if (scan_found) begin
                        rrpv_q[scan_way][lat_index] <= lat_fill;
                        resp_valid <= 1'b1;
                        resp_hit   <= 1'b0;
                        resp_way   <= scan_way;
                        resp_index <= lat_index;
                        state_q    <= RESP;
                    end else begin
                        state_q <= AGE;
                    end
                end
                AGE: begin
                    // Only entered when no way is DISTANT, so +1 cannot wrap.
                    for (int w = 0; w < ASSOCIATIVITY; w++) begin
                        rrpv_q[w][lat_index] <= rrpv_q[w][lat_index] + M'(1);
                    end
                    state_q <= SEARCH;
                end
                RESP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule
